shifter_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one registered 16-bit logarithmic right shifter (data A, fill vector, 4-bit shift amount, result registered on clk) between NUM_REQ requesters.
- Accepts requests over valid/ready, drives the shifter operands from registers, waits out the shifter's one-cycle registered latency, and returns the result tagged with the requester index over a valid/ready response channel.
- Sits between the execution-unit requesters and the single shifter instance.

---
 rtl/shifter_arbiter.sv | 106 ++++++++++
 tb/tb_shifter_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_arbiter.sv
// rtl/shifter_arbiter.sv - round-robin sequencer sharing one registered right shifter
module shifter_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 16,
    parameter int AMT_W   = 4,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*DATA_W-1:0] req_fill,
    input  logic [NUM_REQ*AMT_W-1:0]  req_amt,
    output logic [DATA_W-1:0]         sh_a,
    output logic [DATA_W-1:0]         sh_fill,
    output logic [AMT_W-1:0]          sh_ctrl,
    input  logic [DATA_W-1:0]         sh_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant_idx;
    logic            grant_found;
    logic            grant_window;
    logic            grant;
    int              idx;

    // Rotating priority search starting at rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(idx);
            end
        end
    end

    // The shifter is only free again once the current result has been taken.
    assign grant_window = !rst && ((state == IDLE) || ((state == RESP) && rsp_ready));
    assign grant        = grant_window && grant_found;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = grant ? SHIFT : IDLE;
            SHIFT:   state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = grant ? SHIFT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            sh_a    <= '0;
            sh_fill <= '0;
            sh_ctrl <= '0;
            rsp_id  <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                sh_a    <= req_data[grant_idx*DATA_W +: DATA_W];
                sh_fill <= req_fill[grant_idx*DATA_W +: DATA_W];
                sh_ctrl <= req_amt[grant_idx*AMT_W +: AMT_W];
                rsp_id  <= grant_idx;
                rr_ptr  <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // Operands stay put through RESP, so the shifter output is stable under backpressure.
    assign rsp_valid = (state == RESP);
    assign rsp_data  = sh_result;
    assign busy      = (state != IDLE);

    a_one_grant: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

endmodule

// File: tb/tb_shifter_arbiter.sv
// tb/tb_shifter_arbiter.sv - self-checking bench for shifter_arbiter
module tb_shifter_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_data = '0;
    logic [N*DW-1:0] req_fill = '0;
    logic [N*AW-1:0] req_amt = '0;
    logic [DW-1:0]   sh_a, sh_fill;
    logic [AW-1:0]   sh_ctrl;
    logic [DW-1:0]   sh_result;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [DW-1:0]   rsp_data;
    logic [IW-1:0]   rsp_id;
    logic            busy;

    shifter_arbiter #(.NUM_REQ(N), .DATA_W(DW), .AMT_W(AW), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_fill(req_fill), .req_amt(req_amt),
        .sh_a(sh_a), .sh_fill(sh_fill), .sh_ctrl(sh_ctrl), .sh_result(sh_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the shared shifter: one registered stage, fill supplies vacated top bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sh_result <= '0;
        else     sh_result <= (sh_a >> sh_ctrl) | (sh_fill & ~(16'hFFFF >> sh_ctrl));
    end

    int errors = 0;
    int checks = 0;

    logic [N-1:0]  s_req_ready;
    logic          s_rsp_valid;
    logic [DW-1:0] s_rsp_data;
    logic [IW-1:0] s_rsp_id;
    int            last_grant;

    logic          m_pending = 1'b0;
    int            m_age = 0;
    int            m_ptr = 0;
    logic [DW-1:0] m_data = '0;
    int            m_id = 0;

    typedef struct {
        int            req;
        logic [DW-1:0] a;
        logic [DW-1:0] fill;
        logic [AW-1:0] amt;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_shift(input logic [DW-1:0] a, input logic [DW-1:0] f,
                                                input logic [AW-1:0] m);
        if (f == 16'hFFFF) return ~((~a) >> m);
        return a >> m;
    endfunction

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] f,
                           input logic [AW-1:0] m);
        req_data[i*DW +: DW] = a;
        req_fill[i*DW +: DW] = f;
        req_amt[i*AW +: AW]  = m;
    endtask

    // Called at posedge+1 with inputs set; checks the cycle at negedge and advances the model.
    task automatic cycle_check();
        logic [N-1:0] exp_rr;
        logic         exp_rv;
        logic         window;
        int           g;
        @(negedge clk);
        s_req_ready = req_ready;
        s_rsp_valid = rsp_valid;
        s_rsp_data  = rsp_data;
        s_rsp_id    = rsp_id;
        last_grant  = -1;
        for (int i = 0; i < N; i++) if (s_req_ready[i]) last_grant = i;
        if (rst) begin
            chk("rst_req_ready", s_req_ready, 0);
            chk("rst_rsp_valid", s_rsp_valid, 0);
            chk("rst_busy", busy, 0);
            m_pending = 1'b0;
            m_age     = 0;
            m_ptr     = 0;
        end else begin
            exp_rv = m_pending && (m_age >= 1);
            window = !m_pending || (exp_rv && rsp_ready);
            g = -1;
            if (window) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                end
            end
            exp_rr = '0;
            if (g >= 0) exp_rr[g] = 1'b1;
            chk("req_ready", s_req_ready, exp_rr);
            chk("rsp_valid", s_rsp_valid, exp_rv);
            chk("busy", busy, m_pending);
            if (exp_rv) begin
                chk("rsp_data", s_rsp_data, m_data);
                chk("rsp_id", s_rsp_id, m_id);
            end
            if (exp_rv && rsp_ready) m_pending = 1'b0;
            if (g >= 0) begin
                m_pending = 1'b1;
                m_age     = 0;
                m_data    = ref_shift(req_data[g*DW +: DW], req_fill[g*DW +: DW], req_amt[g*AW +: AW]);
                m_id      = g;
                m_ptr     = (g + 1) % N;
            end else if (m_pending) begin
                m_age++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        cycle_check();
        rst = 1'b0;
    endtask

    int rr_exp[5];

    initial begin
        tbl[0] = '{0, 16'hF0F0, 16'h0000, 4'd4,  16'h0F0F};
        tbl[1] = '{1, 16'h8000, 16'hFFFF, 4'd15, 16'hFFFF};
        tbl[2] = '{3, 16'h1234, 16'h0000, 4'd0,  16'h1234};
        tbl[3] = '{2, 16'hABCD, 16'hFFFF, 4'd8,  16'hFFAB};
        tbl[4] = '{1, 16'h8001, 16'h0000, 4'd1,  16'h4000};
        tbl[5] = '{2, 16'hFFFF, 16'h0000, 4'd15, 16'h0001};
        tbl[6] = '{0, 16'h0000, 16'hFFFF, 4'd1,  16'h8000};
        tbl[7] = '{3, 16'h5A5A, 16'hFFFF, 4'd0,  16'h5A5A};
        rr_exp = '{0, 1, 2, 3, 0};

        #1;
        chk("rst_sh_a", sh_a, 0);
        chk("rst_sh_fill", sh_fill, 0);
        chk("rst_sh_ctrl", sh_ctrl, 0);
        chk("rst_rsp_id", rsp_id, 0);
        do_reset();

        // Isolated single requests: grant at t, response at t+2.
        rsp_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            set_req(tbl[v].req, tbl[v].a, tbl[v].fill, tbl[v].amt);
            req_valid = '0;
            req_valid[tbl[v].req] = 1'b1;
            cycle_check();
            chk("tbl_grant", last_grant, tbl[v].req);
            req_valid = '0;
            cycle_check();
            chk("tbl_latency", s_rsp_valid, 0);
            cycle_check();
            chk("tbl_rsp_valid", s_rsp_valid, 1);
            chk("tbl_rsp_data", s_rsp_data, tbl[v].exp);
            chk("tbl_rsp_id", s_rsp_id, tbl[v].req);
            cycle_check();
            chk("tbl_idle", busy, 0);
        end

        // Round-robin with everyone requesting.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 16'h1111 * (i + 1), 16'h0000, AW'(i));
        req_valid = '1;
        for (int c = 0; c < 10; c++) begin
            cycle_check();
            if (c % 2 == 0) chk("rr_grant", last_grant, rr_exp[c / 2]);
            else            chk("rr_gap", last_grant, -1);
        end
        req_valid = '0;
        cycle_check();
        cycle_check();
        cycle_check();

        // Amount zero from requester 3, then pointer wraps to 0.
        set_req(3, 16'h1234, 16'h0000, 4'd0);
        req_valid = 4'b1000;
        cycle_check();
        chk("wrap_grant3", last_grant, 3);
        req_valid = '0;
        cycle_check();
        set_req(0, 16'h00FF, 16'hFFFF, 4'd4);
        req_valid = 4'b1001;
        cycle_check();
        chk("wrap_rsp_data", s_rsp_data, 16'h1234);
        chk("wrap_rsp_id", s_rsp_id, 3);
        chk("wrap_grant0", last_grant, 0);
        req_valid = '0;
        cycle_check();
        cycle_check();
        cycle_check();

        // Backpressure holds the result and blocks grants.
        set_req(1, 16'h8000, 16'hFFFF, 4'd15);
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        cycle_check();
        chk("bp_grant", last_grant, 1);
        set_req(2, 16'hC3C3, 16'h0000, 4'd2);
        req_valid = 4'b0100;
        cycle_check();
        for (int c = 0; c < 5; c++) begin
            cycle_check();
            chk("bp_hold_data", s_rsp_data, 16'hFFFF);
            chk("bp_no_grant", s_req_ready, 0);
        end
        rsp_ready = 1'b1;
        cycle_check();
        chk("bp_accept_grant", last_grant, 2);
        req_valid = '0;
        cycle_check();
        cycle_check();
        cycle_check();

        // Request withdrawn while the response is stalled.
        set_req(0, 16'h0F00, 16'h0000, 4'd8);
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        cycle_check();
        req_valid = '0;
        cycle_check();
        set_req(2, 16'h7777, 16'hFFFF, 4'd3);
        req_valid = 4'b0100;
        cycle_check();
        chk("wd_no_grant", s_req_ready, 0);
        req_valid = '0;
        cycle_check();
        rsp_ready = 1'b1;
        cycle_check();
        chk("wd_accept_no_grant", s_req_ready, 0);
        for (int c = 0; c < 3; c++) begin
            cycle_check();
            chk("wd_no_spurious", s_rsp_valid, 0);
        end

        // Asynchronous reset during SHIFT.
        set_req(0, 16'hF0F0, 16'hFFFF, 4'd4);
        req_valid = 4'b0001;
        cycle_check();
        req_valid = '0;
        #1;
        rst = 1'b1;
        #1;
        chk("ar_rsp_valid", rsp_valid, 0);
        chk("ar_busy", busy, 0);
        chk("ar_sh_a", sh_a, 0);
        chk("ar_sh_fill", sh_fill, 0);
        chk("ar_sh_ctrl", sh_ctrl, 0);
        cycle_check();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle_check();
            chk("ar_no_rsp", s_rsp_valid, 0);
        end
        set_req(1, 16'hAAAA, 16'h0000, 4'd1);
        set_req(2, 16'h5555, 16'h0000, 4'd1);
        req_valid = 4'b0110;
        cycle_check();
        chk("ar_first_grant", last_grant, 1);
        req_valid = '0;
        cycle_check();
        cycle_check();
        cycle_check();

        // Randomized traffic against the transaction model.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (s_req_ready[i] || !req_valid[i]) begin
                    set_req(i, DW'($urandom), ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h0000,
                            AW'($urandom));
                    req_valid[i] = ($urandom_range(0, 2) == 0);
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle_check();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
